// File: rtl/byte_serializer_tx_pkg.sv
// Shared definitions for the byte serializer: FSM encoding, frame geometry and bit selection.
package byte_serializer_tx_pkg;

    typedef enum logic [1:0] {
        S_WAIT = 2'b00,
        S_TX   = 2'b01,
        S_ACK  = 2'b10
    } state_t;

    localparam int         FRAME_BITS = 10;
    localparam logic       IDLE_LEVEL = 1'b1;
    localparam logic [3:0] STOP_IDX   = 4'(FRAME_BITS - 1);

    // Frame position 0 is the start bit, 1..8 are data LSB first, 9 is the stop bit.
    function automatic logic frame_bit(input logic [7:0] data, input logic [3:0] idx);
        if (idx == 4'd0)
            return 1'b0;
        else if (idx >= STOP_IDX)
            return IDLE_LEVEL;
        else
            return data[3'(idx - 4'd1)];
    endfunction

endpackage

// File: rtl/byte_serializer_tx_bit_timer.sv
// Per-bit timer: 8-bit down-counter reloaded to BIT_CLOCKS-1, ticks on the last clock of a bit.
module byte_serializer_tx_bit_timer #(
    parameter int BIT_CLOCKS = 4
) (
    input  logic clock,
    input  logic reset_,
    input  logic load_i,
    input  logic en_i,
    output logic tick_o
);

    localparam logic [7:0] RELOAD = 8'(BIT_CLOCKS - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = RELOAD;
        else if (en_i)
            cnt_d = (cnt_q == 8'd0) ? RELOAD : cnt_q - 8'd1;
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_)
            cnt_q <= 8'd0;
        else
            cnt_q <= cnt_d;
    end

    assign tick_o = en_i && (cnt_q == 8'd0);

endmodule

// File: rtl/byte_serializer_tx.sv
// Byte-to-serial transmitter: dav_/rfd handshake in, start/8N/stop frame out, idle high.
module byte_serializer_tx
    import byte_serializer_tx_pkg::*;
#(
    parameter int BIT_CLOCKS = 4
) (
    input  logic       clock,
    input  logic       reset_,
    input  logic       dav_,
    input  logic [7:0] byte_in,
    output logic       rfd,
    output logic       out
);

    state_t     state_q, state_d;
    logic [7:0] buf_q, buf_d;
    logic [3:0] idx_q, idx_d;
    logic       out_q, out_d;
    logic       rfd_q, rfd_d;
    logic       load;
    logic       tick;

    byte_serializer_tx_bit_timer #(
        .BIT_CLOCKS(BIT_CLOCKS)
    ) u_timer (
        .clock  (clock),
        .reset_ (reset_),
        .load_i (load),
        .en_i   (state_q == S_TX),
        .tick_o (tick)
    );

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        out_d   = out_q;
        rfd_d   = rfd_q;
        load    = 1'b0;
        case (state_q)
            S_WAIT: begin
                if (!dav_) begin
                    buf_d   = byte_in;
                    rfd_d   = 1'b0;
                    out_d   = 1'b0;
                    idx_d   = 4'd0;
                    load    = 1'b1;
                    state_d = S_TX;
                end
            end
            S_TX: begin
                if (tick) begin
                    if (idx_q == STOP_IDX) begin
                        // Producer still holding dav_ low must release it before we re-arm.
                        if (dav_) begin
                            rfd_d   = 1'b1;
                            state_d = S_WAIT;
                        end else begin
                            state_d = S_ACK;
                        end
                    end else begin
                        idx_d = idx_q + 4'd1;
                        out_d = frame_bit(buf_q, idx_q + 4'd1);
                    end
                end
            end
            S_ACK: begin
                if (dav_) begin
                    rfd_d   = 1'b1;
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_WAIT;
                out_d   = IDLE_LEVEL;
                rfd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= S_WAIT;
            buf_q   <= 8'h00;
            idx_q   <= 4'd0;
            out_q   <= IDLE_LEVEL;
            rfd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            rfd_q   <= rfd_d;
        end
    end

    assign out = out_q;
    assign rfd = rfd_q;

endmodule

// File: tb/tb_byte_serializer_tx.sv
// Directed bench for byte_serializer_tx at BIT_CLOCKS = 4, 1 and 255.
module tb_byte_serializer_tx;

    logic       clock  = 1'b0;
    logic       reset_ = 1'b1;
    logic       dav4_ = 1'b1, dav1_ = 1'b1, dav255_ = 1'b1;
    logic [7:0] byte4 = 8'h00, byte1 = 8'h00, byte255 = 8'h00;
    logic       rfd4, out4, rfd1, out1, rfd255, out255;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    byte_serializer_tx #(.BIT_CLOCKS(4)) dut4 (
        .clock(clock), .reset_(reset_), .dav_(dav4_), .byte_in(byte4), .rfd(rfd4), .out(out4)
    );
    byte_serializer_tx #(.BIT_CLOCKS(1)) dut1 (
        .clock(clock), .reset_(reset_), .dav_(dav1_), .byte_in(byte1), .rfd(rfd1), .out(out1)
    );
    byte_serializer_tx #(.BIT_CLOCKS(255)) dut255 (
        .clock(clock), .reset_(reset_), .dav_(dav255_), .byte_in(byte255), .rfd(rfd255), .out(out255)
    );

    task automatic test_reset;
        #2 reset_ = 1'b0;
        #2;
        total++;
        if ({out4, out1, out255} !== 3'b111) begin
            bad++;
            $display("FAIL reset_out got=%b want=111", {out4, out1, out255});
        end
        total++;
        if ({rfd4, rfd1, rfd255} !== 3'b111) begin
            bad++;
            $display("FAIL reset_rfd got=%b want=111", {rfd4, rfd1, rfd255});
        end
        repeat (2) @(negedge clock);
        reset_ = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            total++;
            if ({out4, out1, out255, rfd4, rfd1, rfd255} !== 6'b111111) begin
                bad++;
                $display("FAIL reset_idle k=%0d got=%b want=111111", k,
                         {out4, out1, out255, rfd4, rfd1, rfd255});
            end
        end
    endtask

    // B=4, 0x0F; dav_ released after T0, a one-clock dav_ glitch and byte change mid-frame.
    task automatic test_basic;
        logic [9:0] pat;
        pat = 10'b1_0000_1111_0;
        @(negedge clock);
        byte4 = 8'h0F;
        dav4_ = 1'b0;
        @(posedge clock);
        #1 dav4_ = 1'b1;
        byte4 = 8'hC3;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            total++;
            if (out4 !== pat[k/4]) begin
                bad++;
                $display("FAIL basic_out k=%0d got=%b want=%b", k, out4, pat[k/4]);
            end
            total++;
            if (rfd4 !== 1'b0) begin
                bad++;
                $display("FAIL basic_rfd k=%0d got=%b want=0", k, rfd4);
            end
            if (k == 20) dav4_ = 1'b0;
            if (k == 21) dav4_ = 1'b1;
        end
        @(negedge clock);
        total++;
        if ({out4, rfd4} !== 2'b11) begin
            bad++;
            $display("FAIL basic_end got=%b want=11", {out4, rfd4});
        end
    endtask

    // B=1, 0x9A then 0x5B as fast as the handshake allows.
    task automatic test_back_to_back;
        logic [9:0] p1, p2;
        p1 = 10'b1_1001_1010_0;
        p2 = 10'b1_0101_1011_0;
        @(negedge clock);
        byte1 = 8'h9A;
        dav1_ = 1'b0;
        @(posedge clock);
        #1 dav1_ = 1'b1;
        byte1 = 8'h00;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            total++;
            if ({out1, rfd1} !== {p1[k], 1'b0}) begin
                bad++;
                $display("FAIL b2b_f1 k=%0d got=%b want=%b", k, {out1, rfd1}, {p1[k], 1'b0});
            end
        end
        @(negedge clock);
        total++;
        if ({out1, rfd1} !== 2'b11) begin
            bad++;
            $display("FAIL b2b_gap got=%b want=11", {out1, rfd1});
        end
        byte1 = 8'h5B;
        dav1_ = 1'b0;
        @(posedge clock);
        #1 dav1_ = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            total++;
            if ({out1, rfd1} !== {p2[k], 1'b0}) begin
                bad++;
                $display("FAIL b2b_f2 k=%0d got=%b want=%b", k, {out1, rfd1}, {p2[k], 1'b0});
            end
        end
        @(negedge clock);
        total++;
        if ({out1, rfd1} !== 2'b11) begin
            bad++;
            $display("FAIL b2b_end got=%b want=11", {out1, rfd1});
        end
    endtask

    // B=4, 0xA5 with dav_ held low until T0+60.
    task automatic test_ack;
        logic [9:0] pat;
        logic       want;
        pat = 10'b1_1010_0101_0;
        @(negedge clock);
        byte4 = 8'hA5;
        dav4_ = 1'b0;
        @(posedge clock);
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            want = (k < 40) ? pat[k/4] : 1'b1;
            total++;
            if ({out4, rfd4} !== {want, 1'b0}) begin
                bad++;
                $display("FAIL ack_hold k=%0d got=%b want=%b", k, {out4, rfd4}, {want, 1'b0});
            end
            if (k == 59) dav4_ = 1'b1;
        end
        @(negedge clock);
        total++;
        if ({out4, rfd4} !== 2'b11) begin
            bad++;
            $display("FAIL ack_release got=%b want=11", {out4, rfd4});
        end
    endtask

    // B=4, 0x05 aborted by reset during data bit 3, then 0xFF.
    task automatic test_reset_midframe;
        logic [9:0] p1, p2;
        p1 = 10'b1_0000_0101_0;
        p2 = 10'b1_1111_1111_0;
        @(negedge clock);
        byte4 = 8'h05;
        dav4_ = 1'b0;
        @(posedge clock);
        #1 dav4_ = 1'b1;
        for (int k = 0; k < 18; k++) begin
            @(negedge clock);
            total++;
            if ({out4, rfd4} !== {p1[k/4], 1'b0}) begin
                bad++;
                $display("FAIL abort_pre k=%0d got=%b want=%b", k, {out4, rfd4}, {p1[k/4], 1'b0});
            end
        end
        reset_ = 1'b0;
        #1;
        total++;
        if ({out4, rfd4} !== 2'b11) begin
            bad++;
            $display("FAIL abort_async got=%b want=11", {out4, rfd4});
        end
        repeat (2) @(negedge clock);
        reset_ = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            total++;
            if ({out4, rfd4} !== 2'b11) begin
                bad++;
                $display("FAIL abort_noresume k=%0d got=%b want=11", k, {out4, rfd4});
            end
        end
        byte4 = 8'hFF;
        dav4_ = 1'b0;
        @(posedge clock);
        #1 dav4_ = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            total++;
            if ({out4, rfd4} !== {p2[k/4], 1'b0}) begin
                bad++;
                $display("FAIL abort_ff k=%0d got=%b want=%b", k, {out4, rfd4}, {p2[k/4], 1'b0});
            end
        end
        @(negedge clock);
        total++;
        if ({out4, rfd4} !== 2'b11) begin
            bad++;
            $display("FAIL abort_ff_end got=%b want=11", {out4, rfd4});
        end
    endtask

    // B=255, 0x00: 2295 low clocks, 255 stop clocks, rfd back at T0+2550.
    task automatic test_long_bit;
        logic want;
        @(negedge clock);
        byte255 = 8'h00;
        dav255_ = 1'b0;
        @(posedge clock);
        #1 dav255_ = 1'b1;
        for (int k = 0; k < 2550; k++) begin
            @(negedge clock);
            want = (k < 2295) ? 1'b0 : 1'b1;
            total++;
            if ({out255, rfd255} !== {want, 1'b0}) begin
                bad++;
                $display("FAIL long_frame k=%0d got=%b want=%b", k, {out255, rfd255}, {want, 1'b0});
            end
        end
        @(negedge clock);
        total++;
        if ({out255, rfd255} !== 2'b11) begin
            bad++;
            $display("FAIL long_end got=%b want=11", {out255, rfd255});
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_ack;
        test_reset_midframe;
        test_long_bit;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/byte_serializer_tx.md
Name: byte_serializer_tx

Overview:
- Downstream consumer of the 8-bit microprogram sequencer output (z7_z0 bus).
- Accepts one byte per dav_/rfd handshake and emits it on a single serial line as a 10-bit frame: start bit 0, 8 data bits LSB first, stop bit 1.
- Each bit is held for BIT_CLOCKS clock periods; the line idles at 1.
- At BIT_CLOCKS=1 a full frame is 10 clocks, matching the sequencer's 10-clock output hold time.

Parameters:
- BIT_CLOCKS, default 4: clock periods per serial bit; legal range 1..255.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset_  input  1  asynchronous, active-low reset.
- dav_  input  1  data-available strobe from the producer, active low.
- byte_in  input  8  byte to transmit; stable while dav_=0.
- rfd  output  1  ready-for-data to the producer, active high.
- out  output  1  serial line; idle level 1.

Behaviour:
- Clocking and reset: one clock (clock); reset is asynchronous and active-low (reset_).
- While reset_=0: out=1, rfd=1, state=S_WAIT, internal buffer=8'h00, bit and cycle counters=0. Asserting reset mid-frame aborts the frame immediately with out=1, and no partial frame resumes after reset.
- States: S_WAIT, S_TX, S_ACK. All outputs are registered.
- S_WAIT (rfd=1, out=1):
  - At an edge T0 with dav_=0: buffer<=byte_in, rfd<=0, out<=0 (start bit), bit index<=0, cycle counter<=BIT_CLOCKS-1, then go to S_TX.
  - With dav_=1: hold.
- S_TX, per-bit timing:
  - Each bit occupies exactly BIT_CLOCKS clocks.
  - Start bit occupies [T0, T0+B).
  - Data bit i (i=0..7) occupies [T0+(i+1)B, T0+(i+2)B) with out=buffer[i].
  - Stop bit occupies [T0+9B, T0+10B) with out=1.
- S_TX, counting and exit:
  - The cycle counter decrements each clock and reloads to B-1 at each bit boundary.
  - byte_in and dav_ are ignored during S_TX; the byte is latched only at T0.
  - At edge T0+10B, if dav_=1: rfd<=1 and go to S_WAIT. If dav_=0: go to S_ACK.
- S_ACK (rfd=0, out=1): at the first edge with dav_=1, rfd<=1 and go to S_WAIT.
- Throughput:
  - Minimum handshake period is 10B+1 clocks, because the producer needs one edge to see rfd=1.
  - Back-to-back frames therefore have at least one idle-1 clock between the stop bit and the next start bit.
- Boundary conditions:
  - B=1 gives a 10-clock frame.
  - B=255 requires an 8-bit cycle counter with no wrap error.
  - Bytes 8'h00 and 8'hFF must be framed correctly, with the start bit still 0 and the stop bit still 1.
  - dav_ going high mid-frame does not shorten or abort the frame.
  - A dav_ glitch to 0 while rfd=0 has no effect.

Decomposition:
- Shared constants file (txdefs.vh):
  - State encodings: S_WAIT=2'b00, S_TX=2'b01, S_ACK=2'b10.
  - FRAME_BITS=10.
  - IDLE_LEVEL=1'b1.
- One natural sub-module, bit_timer:
  - Loadable 8-bit down-counter with reload value BIT_CLOCKS-1.
  - Outputs a one-cycle tick at zero.
  - Same clock and reset_ as the parent.
- The parent FSM holds the buffer, the 4-bit bit index (0..9) and the out/rfd registers.

Test Plan:
1. Reset: reset_=0 for 1 half-period, then check out=1 and rfd=1; release reset and check out stays 1 for 20 clocks with dav_=1.
2. B=4, byte_in=8'h0F, dav_=0 at T0: out must be 0 for 4 clocks, then 1,1,1,1,0,0,0,0 (4 clocks each), then stop 1 for 4 clocks. rfd=0 from T0+1 edge until T0+40. Total frame 40 clocks.
3. B=1, byte 8'h9A, then 8'h5B back-to-back (dav_ released during frame): frames 10 clocks each, exactly 1 idle clock between them. Serial bits of 8'h9A LSB-first are 0,1,0,1,1,0,0,1.
4. B=4, dav_ held 0 until T0+60: rfd must stay 0 through S_ACK and rise one edge after dav_=1; out=1 from T0+40 onward.
5. B=4, assert reset_=0 at T0+17 (mid data bit 3): out=1 and rfd=1 immediately, without waiting for an edge. After release, a new byte 8'hFF yields start 0, eight 1s, stop 1.
6. B=255, byte 8'h00: start plus 8 data bits give 0 for 9×255=2295 clocks, then stop 1 for 255 clocks. rfd returns high at T0+2550.
